num_ascii_tx: RTL and testbench
===============================

NUM_ASCII_TX -- requirements
Module: num_ascii_tx

Interface
REQ-001 The module SHALL have parameter TERM_EN, default 0, meaning 1 appends CR (8'h0D) and LF (8'h0A) after the four digits.
REQ-002 The module SHALL have port clk, input, 1 bit, system clock with all logic on its rising edge.
REQ-003 The module SHALL have port rst_n, input, 1 bit, asynchronous active-low reset.
REQ-004 The module SHALL have port send, input, 1 bit, one-cycle request to transmit num.
REQ-005 The module SHALL have port num, input, 32 bits, unsigned value to report, sampled only in the send cycle.
REQ-006 The module SHALL have port tx_done, input, 1 bit, one-cycle pulse from the UART transmitter when the current byte has finished.
REQ-007 The module SHALL have port tx_start, output, 1 bit, one-cycle pulse requesting the UART transmitter to send tx_data.
REQ-008 The module SHALL have port tx_data, output, 8 bits, byte to send, valid in the tx_start cycle and held until the next tx_start.
REQ-009 The module SHALL have port busy, output, 1 bit, high from the cycle after send is accepted until the cycle done pulses.
REQ-010 The module SHALL have port done, output, 1 bit, one-cycle pulse when the frame is complete.
REQ-011 The module SHALL have port ovf, output, 1 bit, high when the last accepted num exceeded 9999; it updates on each accepted send.

Function
REQ-012 The FSM SHALL use the states IDLE, CONV, LOAD, WAIT, and FIN.
REQ-013 In IDLE, send SHALL be accepted: num is captured, saturated to 9999 if above 9999, ovf is set accordingly, and the FSM moves to CONV.
REQ-014 CONV SHALL perform a sequential 14-bit binary-to-BCD conversion (double-dabble), one bit per cycle for exactly 14 cycles, then move to LOAD.
REQ-015 The frame SHALL be 4 ASCII digits, thousands first, each digit + 8'h30, with leading zeros sent as '0'; if TERM_EN=1, 8'h0D and 8'h0A SHALL follow.
REQ-016 LOAD SHALL drive tx_data with the current byte, pulse tx_start for one cycle, and move to WAIT.
REQ-017 WAIT SHALL hold until tx_done; on tx_done it SHALL go to LOAD if bytes remain, otherwise to FIN.
REQ-018 FIN SHALL pulse done for one cycle and return to IDLE, with busy low in that same cycle.
REQ-019 Latency: send accepted in cycle N -> first tx_start in cycle N+16; tx_done in cycle M -> next tx_start in cycle M+1; last tx_done in cycle M -> done in cycle M+1.
REQ-020 send while not in IDLE SHALL be ignored, with no queuing and no effect on ovf.
REQ-021 tx_done outside WAIT SHALL be ignored.
REQ-022 A byte index SHALL count 0..3 (or 0..5 when TERM_EN=1) and reset to 0 on each accepted send.
REQ-023 No more than one tx_start SHALL be outstanding; there SHALL be exactly one tx_start per byte.

Reset
REQ-024 On rst_n low, the FSM SHALL go to IDLE, the index and BCD registers SHALL clear, and tx_start=0, tx_data=8'h00, busy=0, done=0, ovf=0.
REQ-025 Reset asserted mid-frame SHALL abort the frame, and no further tx_start SHALL occur until a new send.
REQ-026 After reset release, the first send SHALL behave per REQ-019.

Structure
REQ-027 A shared package SHALL hold ASCII_ZERO=8'h30, ASCII_CR=8'h0D, ASCII_LF=8'h0A, NUM_DIGITS=4, MAX_VAL=9999, CONV_BITS=14, and the FSM state type.
REQ-028 The BCD conversion SHALL be the sub-module bin2bcd_seq, with start/ready handshake, 14-bit input, and 16-bit BCD output.

Verification
REQ-029 send with num=1234 and tx_done 10 cycles after each tx_start -> bytes 31 32 33 34, first tx_start at N+16, done once, ovf=0.
REQ-030 num=0 -> 30 30 30 30; num=7 -> 30 30 30 37.
REQ-031 num=12345 -> 39 39 39 39 and ovf=1; a following num=9999 -> 39 39 39 39 and ovf=0.
REQ-032 send pulsed during byte 2 of the frame for 5678 -> frame unchanged, exactly 4 tx_start pulses, no second frame.
REQ-033 rst_n low after the second tx_start -> all outputs at reset values, no tx_start for 100 cycles; a new send of 42 -> 30 30 34 32.
REQ-034 TERM_EN=1, num=905, tx_done delays randomized 1..50 cycles -> 30 39 30 35 0D 0A, done one cycle after the sixth tx_done.

Source files
------------

// File: rtl/num_ascii_tx_pkg.sv
// Shared constants, FSM state type and frame byte selection for num_ascii_tx.
package num_ascii_tx_pkg;
   localparam logic [7:0] ASCII_ZERO = 8'h30;
   localparam logic [7:0] ASCII_CR   = 8'h0D;
   localparam logic [7:0] ASCII_LF   = 8'h0A;
   localparam int NUM_DIGITS = 4;
   localparam int MAX_VAL    = 9999;
   localparam int CONV_BITS  = 14;

   typedef enum logic [2:0] {IDLE, CONV, LOAD, WAIT, FIN} state_t;

   // Byte idx of the frame: four digits thousands first, then CR, LF.
   function automatic logic [7:0] frame_byte(input logic [15:0] bcd, input logic [2:0] idx);
      logic [7:0] b;
      b = ASCII_LF;
      case (idx)
         3'd0:    b = ASCII_ZERO + {4'h0, bcd[15:12]};
         3'd1:    b = ASCII_ZERO + {4'h0, bcd[11:8]};
         3'd2:    b = ASCII_ZERO + {4'h0, bcd[7:4]};
         3'd3:    b = ASCII_ZERO + {4'h0, bcd[3:0]};
         3'd4:    b = ASCII_CR;
         default: b = ASCII_LF;
      endcase
      return b;
   endfunction
endpackage

// File: rtl/num_ascii_tx_bin2bcd.sv
// Sequential double-dabble: one input bit per cycle, ready once all bits are in.
module bin2bcd_seq
   import num_ascii_tx_pkg::*;
(
   input  logic                 clk,
   input  logic                 rst_n,
   input  logic                 start,
   input  logic [CONV_BITS-1:0] bin,
   output logic                 ready,
   output logic [15:0]          bcd
);
   logic [CONV_BITS-1:0] shreg;
   logic [3:0]           cnt;
   logic                 active;
   logic [15:0]          bcd_adj;

   function automatic logic [15:0] dabble(input logic [15:0] v);
      logic [15:0] r;
      r = v;
      for (int i = 0; i < NUM_DIGITS; i++) begin
         if (v[4*i +: 4] >= 4'd5) r[4*i +: 4] = v[4*i +: 4] + 4'd3;
      end
      return r;
   endfunction

   assign bcd_adj = dabble(bcd);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         shreg  <= '0;
         bcd    <= '0;
         cnt    <= '0;
         active <= 1'b0;
         ready  <= 1'b0;
      end else if (start) begin
         shreg  <= bin;
         bcd    <= '0;
         cnt    <= 4'(CONV_BITS);
         active <= 1'b1;
         ready  <= 1'b0;
      end else if (active) begin
         bcd   <= {bcd_adj[14:0], shreg[CONV_BITS-1]};
         shreg <= shreg << 1;
         cnt   <= cnt - 4'd1;
         if (cnt == 4'd1) begin
            active <= 1'b0;
            ready  <= 1'b1;
         end
      end
   end
endmodule

// File: rtl/num_ascii_tx.sv
// Reports a number as a 4-digit ASCII frame (optional CR LF) through a UART byte handshake.
module num_ascii_tx
   import num_ascii_tx_pkg::*;
#(
   parameter int TERM_EN = 0
)
(
   input  logic        clk,
   input  logic        rst_n,
   input  logic        send,
   input  logic [31:0] num,
   input  logic        tx_done,
   output logic        tx_start,
   output logic [7:0]  tx_data,
   output logic        busy,
   output logic        done,
   output logic        ovf
);
   localparam logic [2:0] LAST_IDX = (TERM_EN != 0) ? 3'd5 : 3'd3;

   state_t               state;
   logic [2:0]           idx;
   logic [CONV_BITS-1:0] num_sat;
   logic                 accept;
   logic                 conv_ready;
   logic [15:0]          bcd;

   assign accept  = (state == IDLE) && send;
   assign num_sat = (num > 32'(MAX_VAL)) ? CONV_BITS'(MAX_VAL) : num[CONV_BITS-1:0];

   bin2bcd_seq u_bcd (
      .clk   (clk),
      .rst_n (rst_n),
      .start (accept),
      .bin   (num_sat),
      .ready (conv_ready),
      .bcd   (bcd)
   );

   // tx_start/tx_data are registered on the way into LOAD, so the pulse is
   // visible during the LOAD cycle itself, one cycle after the triggering event.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state    <= IDLE;
         idx      <= '0;
         tx_start <= 1'b0;
         tx_data  <= 8'h00;
         busy     <= 1'b0;
         done     <= 1'b0;
         ovf      <= 1'b0;
      end else begin
         tx_start <= 1'b0;
         done     <= 1'b0;
         case (state)
            IDLE: if (send) begin
               ovf   <= (num > 32'(MAX_VAL));
               idx   <= '0;
               busy  <= 1'b1;
               state <= CONV;
            end
            CONV: if (conv_ready) begin
               tx_data  <= frame_byte(bcd, 3'd0);
               tx_start <= 1'b1;
               state    <= LOAD;
            end
            LOAD: state <= WAIT;
            WAIT: if (tx_done) begin
               if (idx != LAST_IDX) begin
                  idx      <= idx + 3'd1;
                  tx_data  <= frame_byte(bcd, idx + 3'd1);
                  tx_start <= 1'b1;
                  state    <= LOAD;
               end else begin
                  done  <= 1'b1;
                  busy  <= 1'b0;
                  state <= FIN;
               end
            end
            FIN:     state <= IDLE;
            default: state <= IDLE;
         endcase
      end
   end
endmodule

// File: tb/tb_num_ascii_tx.sv
// Directed bench for num_ascii_tx: table of frames plus hand-written corner sequences.
module tb_num_ascii_tx;
   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic        rst_n;
   logic        send_i    [2];
   logic [31:0] num_i     [2];
   logic        tx_done_i [2];
   logic        tx_start_o[2];
   logic [7:0]  tx_data_o [2];
   logic        busy_o    [2];
   logic        done_o    [2];
   logic        ovf_o     [2];

   num_ascii_tx #(.TERM_EN(0)) dut0 (
      .clk(clk), .rst_n(rst_n), .send(send_i[0]), .num(num_i[0]), .tx_done(tx_done_i[0]),
      .tx_start(tx_start_o[0]), .tx_data(tx_data_o[0]), .busy(busy_o[0]), .done(done_o[0]),
      .ovf(ovf_o[0]));

   num_ascii_tx #(.TERM_EN(1)) dut1 (
      .clk(clk), .rst_n(rst_n), .send(send_i[1]), .num(num_i[1]), .tx_done(tx_done_i[1]),
      .tx_start(tx_start_o[1]), .tx_data(tx_data_o[1]), .busy(busy_o[1]), .done(done_o[1]),
      .ovf(ovf_o[1]));

   typedef struct {
      logic [31:0] num;
      int          s;
      int          nb;
      logic [47:0] bytes;
      logic        ovf;
   } vec_t;

   int pass_cnt = 0;
   int chk_cnt  = 0;

   logic [7:0] got_q[$];
   int first_cyc, done_cnt, done_cyc, last_tx_done_cyc;
   int gap_err, overlap_err, busy_err;

   task automatic check(input string name, input longint got, input longint exp);
      chk_cnt++;
      if (got == exp) pass_cnt++;
      else $display("FAIL %s: got %0h expected %0h", name, got, exp);
   endtask

   // Drives one frame on DUT s; called at a negedge. dly=0 means random 1..50.
   task automatic run_frame(input int s, input logic [31:0] n, input int dly,
                            input int inj_after, input int rst_after);
      int  cyc, next_done, last_start;
      bit  injected;
      got_q.delete();
      first_cyc = -1; done_cnt = 0; done_cyc = -1; last_tx_done_cyc = -1;
      gap_err = 0; overlap_err = 0; busy_err = 0;
      next_done = -1; injected = 0; last_start = -1;
      if (busy_o[s] !== 1'b0) busy_err++;
      send_i[s] = 1'b1;
      num_i[s]  = n;
      cyc = 0;
      for (int k = 0; k < 3000; k++) begin
         @(negedge clk);
         cyc++;
         send_i[s]    = 1'b0;
         tx_done_i[s] = 1'b0;
         if (cyc == 1 && busy_o[s] !== 1'b1) busy_err++;
         if (tx_start_o[s] === 1'b1) begin
            got_q.push_back(tx_data_o[s]);
            if (first_cyc < 0) first_cyc = cyc;
            else if (cyc != last_tx_done_cyc + 1) gap_err++;
            if (next_done >= 0) overlap_err++;
            last_start = cyc;
            next_done = cyc + ((dly > 0) ? dly : int'($urandom_range(50, 1)));
         end
         if (done_o[s] === 1'b1) begin
            done_cnt++;
            done_cyc = cyc;
            if (busy_o[s] !== 1'b0) busy_err++;
         end
         if (rst_after > 0 && got_q.size() == rst_after) begin
            rst_n = 1'b0;
            return;
         end
         if (cyc == next_done) begin
            tx_done_i[s] = 1'b1;
            last_tx_done_cyc = cyc;
            next_done = -1;
         end
         if (inj_after > 0 && !injected && got_q.size() == inj_after && cyc == last_start + 3) begin
            send_i[s] = 1'b1;
            num_i[s]  = 32'd12345;
            injected  = 1;
         end
         if (done_cnt > 0 && cyc > done_cyc + 40) break;
      end
      send_i[s]    = 1'b0;
      tx_done_i[s] = 1'b0;
   endtask

   task automatic check_frame(input string name, input int s, input int nb,
                              input logic [47:0] eb, input logic eo);
      longint g;
      check({name, " nbytes"}, got_q.size(), nb);
      for (int i = 0; i < nb; i++) begin
         g = (i < got_q.size()) ? longint'(got_q[i]) : -1;
         check($sformatf("%s byte%0d", name, i), g, eb[47-8*i -: 8]);
      end
      check({name, " first_lat"}, first_cyc, 16);
      check({name, " done_cnt"}, done_cnt, 1);
      check({name, " done_lat"}, done_cyc - last_tx_done_cyc, 1);
      check({name, " gap"}, gap_err, 0);
      check({name, " overlap"}, overlap_err, 0);
      check({name, " busy"}, busy_err, 0);
      check({name, " ovf"}, ovf_o[s], eo);
   endtask

   vec_t vt[6];
   int   stray;

   initial begin
      vt[0] = '{32'd1234,  0, 4, 48'h31_32_33_34_00_00, 1'b0};
      vt[1] = '{32'd0,     0, 4, 48'h30_30_30_30_00_00, 1'b0};
      vt[2] = '{32'd7,     0, 4, 48'h30_30_30_37_00_00, 1'b0};
      vt[3] = '{32'd12345, 0, 4, 48'h39_39_39_39_00_00, 1'b1};
      vt[4] = '{32'd9999,  0, 4, 48'h39_39_39_39_00_00, 1'b0};
      vt[5] = '{32'd905,   1, 6, 48'h30_39_30_35_0D_0A, 1'b0};

      rst_n = 1'b0;
      for (int i = 0; i < 2; i++) begin
         send_i[i] = 1'b0; num_i[i] = 32'hFFFF_FFFF; tx_done_i[i] = 1'b0;
      end
      repeat (3) @(negedge clk);
      check("rst tx_start", tx_start_o[0], 0);
      check("rst tx_data",  tx_data_o[0],  0);
      check("rst busy",     busy_o[0],     0);
      check("rst done",     done_o[0],     0);
      check("rst ovf",      ovf_o[0],      0);
      rst_n = 1'b1;
      repeat (2) @(negedge clk);

      for (int v = 0; v < 6; v++) begin
         run_frame(vt[v].s, vt[v].num, 10, 0, 0);
         check_frame($sformatf("vec%0d", v), vt[v].s, vt[v].nb, vt[v].bytes, vt[v].ovf);
      end

      run_frame(1, 32'd905, 0, 0, 0);
      check_frame("term_rand", 1, 6, 48'h30_39_30_35_0D_0A, 1'b0);

      run_frame(0, 32'd5678, 10, 2, 0);
      check_frame("inject", 0, 4, 48'h35_36_37_38_00_00, 1'b0);

      run_frame(0, 32'd12345, 10, 0, 2);
      #1;
      check("abort tx_start", tx_start_o[0], 0);
      check("abort tx_data",  tx_data_o[0],  0);
      check("abort busy",     busy_o[0],     0);
      check("abort done",     done_o[0],     0);
      check("abort ovf",      ovf_o[0],      0);
      @(negedge clk);
      rst_n = 1'b1;
      stray = 0;
      for (int c = 0; c < 100; c++) begin
         @(negedge clk);
         tx_done_i[0] = (c % 7 == 3);
         if (tx_start_o[0] === 1'b1 || done_o[0] === 1'b1) stray++;
      end
      tx_done_i[0] = 1'b0;
      @(negedge clk);
      check("abort quiet", stray, 0);

      run_frame(0, 32'd42, 10, 0, 0);
      check_frame("after_rst", 0, 4, 48'h30_30_34_32_00_00, 1'b0);

      $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
      $finish;
   end
endmodule
